// File: rtl/jtcontra_pkg.sv
// Shared definitions for the CONTRA ROM arbiter: FSM states and requester indices.
package jtcontra_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_SCR = 0;
  localparam int unsigned REQ_OBJ = 1;

endpackage

// File: rtl/jtcontra_arb_pick.sv
// Combinational pending detection and grant selection for the two ROM requesters.
module jtcontra_arb_pick #(
  parameter int AW = 18
) (
  input  logic [1:0]    i_cs,
  input  logic [1:0]    i_en,
  input  logic [1:0]    i_ok,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [AW-1:0] i_served0,
  input  logic [AW-1:0] i_served1,
  input  logic          i_last,
  output logic          o_any,
  output logic          o_sel
);
  import jtcontra_pkg::*;

  logic [1:0] w_pend;

  always_comb begin
    w_pend          = '0;
    w_pend[REQ_SCR] = i_cs[REQ_SCR] & i_en[REQ_SCR] &
                      (~i_ok[REQ_SCR] | (i_addr0 != i_served0));
    w_pend[REQ_OBJ] = i_cs[REQ_OBJ] & i_en[REQ_OBJ] &
                      (~i_ok[REQ_OBJ] | (i_addr1 != i_served1));
    o_any = |w_pend;
    // On a tie the requester not named by i_last wins
    if (&w_pend) o_sel = ~i_last;
    else         o_sel = w_pend[REQ_OBJ];
  end

endmodule

// File: rtl/jtcontra_rom_arb.sv
// Two-requester SDRAM ROM arbiter (tilemap / objects) with registered data return.
// Optional round-robin arbitration via JTCONTRA_ARB_RR_EN; default is fixed req0 priority.
module jtcontra_rom_arb #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    en,
  input  logic          req0_cs,
  input  logic [AW-1:0] req0_addr,
  output logic          req0_ok,
  output logic [DW-1:0] req0_data,
  input  logic          req1_cs,
  input  logic [AW-1:0] req1_addr,
  output logic          req1_ok,
  output logic [DW-1:0] req1_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  output logic          busy
);
  import jtcontra_pkg::*;

  arb_state_t    r_state, w_state_nxt;
  logic [1:0]    w_cs;
  logic [AW-1:0] w_addr [2];
  logic [1:0]    r_ok;
  logic [DW-1:0] r_data [2];
  logic [AW-1:0] r_served [2];
  logic          r_gnt;
  logic          w_any, w_sel, w_last;
  logic          w_grant, w_done;
  logic [1:0]    w_grant_oh, w_done_oh;

  assign w_cs            = {req1_cs, req0_cs};
  assign w_addr[REQ_SCR] = req0_addr;
  assign w_addr[REQ_OBJ] = req1_addr;

`ifdef JTCONTRA_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= 1'b0;
    else if (w_grant) r_last <= w_sel;
  end
  assign w_last = r_last;
`else
  // Pretending req1 was always last served yields fixed req0 priority
  assign w_last = 1'b1;
`endif

  jtcontra_arb_pick #(.AW(AW)) u_pick (
    .i_cs      (w_cs),
    .i_en      (en),
    .i_ok      (r_ok),
    .i_addr0   (req0_addr),
    .i_addr1   (req1_addr),
    .i_served0 (r_served[REQ_SCR]),
    .i_served1 (r_served[REQ_OBJ]),
    .i_last    (w_last),
    .o_any     (w_any),
    .o_sel     (w_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // GUARD never looks at rom_ok: it may still be high from the previous access
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GUARD;
          w_grant     = 1'b1;
        end
      end
      GUARD: w_state_nxt = WAIT;
      WAIT: begin
        if (rom_ok) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_grant_oh = {w_grant & w_sel, w_grant & ~w_sel};
    w_done_oh  = {w_done & r_gnt, w_done & ~r_gnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      r_gnt    <= 1'b0;
      r_ok     <= '0;
      for (int unsigned n = 0; n < 2; n++) begin
        r_data[n]   <= '0;
        r_served[n] <= '0;
      end
    end else begin
      if (w_grant) begin
        rom_cs   <= 1'b1;
        rom_addr <= w_addr[w_sel];
        r_gnt    <= w_sel;
      end else if (w_done) begin
        rom_cs <= 1'b0;
      end
      // Later assignments take precedence: delivery beats every clear
      for (int unsigned n = 0; n < 2; n++) begin
        if (!w_cs[n]) begin
          r_ok[n] <= 1'b0;
        end else if (!en[n]) begin
          r_ok[n]   <= 1'b1;
          r_data[n] <= '0;
        end else if (w_addr[n] != r_served[n]) begin
          r_ok[n] <= 1'b0;
        end
        if (w_grant_oh[n]) r_ok[n] <= 1'b0;
        if (w_done_oh[n]) begin
          r_ok[n]     <= 1'b1;
          r_data[n]   <= rom_data;
          r_served[n] <= rom_addr;
        end
      end
    end
  end

  assign req0_ok   = r_ok[REQ_SCR];
  assign req1_ok   = r_ok[REQ_OBJ];
  assign req0_data = r_data[REQ_SCR];
  assign req1_data = r_data[REQ_OBJ];
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// Self-checking bench for jtcontra_rom_arb: directed scenarios then randomized traffic
// against a transaction-level requester/ROM model.
module tb_jtcontra_rom_arb;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    en;
  logic          req0_cs, req1_cs;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_ok, req1_ok;
  logic [DW-1:0] req0_data, req1_data;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;
  logic          busy;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  jtcontra_rom_arb #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req0_cs   (req0_cs),
    .req0_addr (req0_addr),
    .req0_ok   (req0_ok),
    .req0_data (req0_data),
    .req1_cs   (req1_cs),
    .req1_addr (req1_addr),
    .req1_ok   (req1_ok),
    .req1_data (req1_data),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {14'd0, a} * 32'h9E37_79B1;
    return x[31:16] ^ {14'd0, a[17:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic cs_of(input int n);
    return (n == 1) ? req1_cs : req0_cs;
  endfunction
  function automatic logic [AW-1:0] addr_of(input int n);
    return (n == 1) ? req1_addr : req0_addr;
  endfunction
  function automatic logic ok_of(input int n);
    return (n == 1) ? req1_ok : req0_ok;
  endfunction
  function automatic logic [DW-1:0] data_of(input int n);
    return (n == 1) ? req1_data : req0_data;
  endfunction

  task automatic set_req(input int n, input logic cs, input logic [AW-1:0] a);
    if (n == 1) begin req1_cs = cs; req1_addr = a; end
    else        begin req0_cs = cs; req0_addr = a; end
  endtask

  task automatic wait_rom_cs(input logic lvl, input string tag);
    int k = 0;
    while (rom_cs !== lvl && k < 50) begin
      step();
      k++;
    end
    chk(tag, rom_cs, lvl);
  endtask

  task automatic serve(input logic [AW-1:0] exp_a, input logic [DW-1:0] d, input int dly);
    wait_rom_cs(1'b1, "srv_cs");
    chk("srv_addr", rom_addr, exp_a);
    repeat (dly) step();
    rom_data = d;
    rom_ok   = 1'b1;
    wait_rom_cs(1'b0, "srv_done");
    rom_ok   = 1'b0;
    rom_data = '0;
  endtask

  // Randomized-phase model state
  logic [AW-1:0] m_pp [2];
  bit            m_wait [2];
  int            m_cnt [2];
  int            m_infl = -1;
  bit            m_last = 1'b0;
  logic          p_rom_cs = 1'b0;
  logic [AW-1:0] p_rom_addr = '0;
  bit            r_resp = 1'b0;
  int            r_dly = 0;
  int            r_stale = 0;

  task automatic model_check();
    int win;
    chk("busy", busy, rom_cs);
    if (p_rom_cs && rom_cs) chk("rom_stable", rom_addr, p_rom_addr);
    if (rom_cs && !p_rom_cs) begin
`ifdef JTCONTRA_ARB_RR_EN
      if (m_wait[0] && m_wait[1]) win = m_last ? 0 : 1;
`else
      if (m_wait[0] && m_wait[1]) win = 0;
`endif
      else win = m_wait[1] ? 1 : 0;
      chk("grant_src", m_wait[0] | m_wait[1], 1);
      chk("grant_addr", rom_addr, addr_of(win));
      m_infl = win;
      m_last = win[0];
    end
    for (int n = 0; n < 2; n++) begin
      if (!cs_of(n)) begin
        chk("ok_clr", ok_of(n), 0);
      end else if (!en[n]) begin
        chk("dis_ok", ok_of(n), 1);
        chk("dis_data", data_of(n), 0);
      end else if (addr_of(n) != m_pp[n]) begin
        chk("ok_newaddr", ok_of(n), 0);
      end else if (ok_of(n)) begin
        chk("data", data_of(n), romf(addr_of(n)));
        if (m_wait[n]) begin
          chk("ok_src", m_infl, n);
          m_wait[n] = 1'b0;
          m_infl    = -1;
        end
      end
      if (m_wait[n]) begin
        m_cnt[n]++;
        if (m_cnt[n] > 80) begin
          chk("timeout", 0, 1);
          m_wait[n] = 1'b0;
        end
      end
      m_pp[n] = addr_of(n);
    end
    p_rom_cs   = rom_cs;
    p_rom_addr = rom_addr;
  endtask

  // ROM responder: random latency, and rom_ok may linger up to two cycles with stale data
  task automatic rsp_tick();
    if (r_resp && !rom_cs) begin
      r_resp  = 1'b0;
      r_stale = $urandom_range(0, 2);
    end
    if (rom_cs && !r_resp) begin
      if (r_dly == 0) begin
        r_resp   = 1'b1;
        rom_data = romf(rom_addr);
      end else r_dly--;
    end
    if (!rom_cs) r_dly = $urandom_range(0, 4);
    if (r_resp) rom_ok = 1'b1;
    else if (r_stale > 0) begin
      rom_ok = 1'b1;
      r_stale--;
    end else begin
      rom_ok   = 1'b0;
      rom_data = DW'($urandom);
    end
  endtask

  task automatic drive_reqs(input bit allow_new);
    int unsigned r;
    logic [AW-1:0] na;
    for (int n = 0; n < 2; n++) begin
      if (!m_wait[n]) begin
        r = $urandom_range(0, 9);
        if (!allow_new || r < 3) begin
          set_req(n, 1'b0, addr_of(n));
        end else if (r >= 6) begin
          na = (r == 9) ? '1 : AW'($urandom);
          if (cs_of(n) && na == addr_of(n)) na = na ^ AW'(1);
          set_req(n, 1'b1, na);
          m_wait[n] = en[n];
          m_cnt[n]  = 0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] segs [4];
    int         first;
    segs = '{2'b11, 2'b01, 2'b10, 2'b11};
    rst = 1'b1; en = 2'b11;
    req0_cs = 1'b0; req1_cs = 1'b0; req0_addr = '0; req1_addr = '0;
    rom_data = '0; rom_ok = 1'b0;
    step(); step();
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", {req1_ok, req0_ok}, 0);
    chk("rst_data", {req1_data, req0_data}, 0);
    rst = 1'b0;
    step();

    // Basic fetch with rom_ok four cycles after rom_cs
    set_req(0, 1'b1, 18'h01234);
    serve(18'h01234, 16'hBEEF, 3);
    chk("t1_ok0", req0_ok, 1);
    chk("t1_data0", req0_data, 16'hBEEF);
    chk("t1_ok1", req1_ok, 0);
    chk("t1_busy", busy, 0);
    step();
    chk("t1_norefetch", rom_cs, 0);
    chk("t1_okhold", req0_ok, 1);
    set_req(0, 1'b0, 18'h01234);
    step();
    chk("t1_okclr", req0_ok, 0);

    // Simultaneous requests
    set_req(0, 1'b1, 18'h00100);
    set_req(1, 1'b1, 18'h00200);
`ifdef JTCONTRA_ARB_RR_EN
    first = 1;
`else
    first = 0;
`endif
    serve(first ? 18'h00200 : 18'h00100, romf(first ? 18'h00200 : 18'h00100), 1);
    chk("t2_gap", rom_cs, 0);
    chk("t2_first_ok", ok_of(first), 1);
    serve(first ? 18'h00100 : 18'h00200, romf(first ? 18'h00100 : 18'h00200), 0);
    chk("t2_ok0", req0_ok, 1);
    chk("t2_data0", req0_data, romf(18'h00100));
    chk("t2_ok1", req1_ok, 1);
    chk("t2_data1", req1_data, romf(18'h00200));
    set_req(0, 1'b0, '0); set_req(1, 1'b0, '0);
    step(); step();

    // Disabled requester answers locally with zero data
    en = 2'b10;
    set_req(0, 1'b1, 18'h00055);
    set_req(1, 1'b1, 18'h00300);
    step();
    chk("t3_ok0", req0_ok, 1);
    chk("t3_data0", req0_data, 0);
    chk("t3_rom_cs", rom_cs, 1);
    chk("t3_rom_addr", rom_addr, 18'h00300);
    serve(18'h00300, romf(18'h00300), 2);
    chk("t3_ok1", req1_ok, 1);
    chk("t3_data1", req1_data, romf(18'h00300));
    chk("t3_ok0_hold", req0_ok, 1);
    set_req(0, 1'b0, '0); set_req(1, 1'b0, '0);
    en = 2'b11;
    step(); step();

    // Stale rom_ok lingering into the next GUARD; wrap-edge address
    set_req(0, 1'b1, 18'h00400);
    wait_rom_cs(1'b1, "t4_cs0");
    set_req(1, 1'b1, 18'h3FFFF);
    rom_data = romf(18'h00400);
    rom_ok   = 1'b1;
    step(); step();
    chk("t4_ok0", req0_ok, 1);
    chk("t4_data0", req0_data, romf(18'h00400));
    chk("t4_idle", rom_cs, 0);
    step();
    chk("t4_cs1", rom_cs, 1);
    chk("t4_addr1", rom_addr, 18'h3FFFF);
    step();
    chk("t4_guard_ignored", req1_ok, 0);
    rom_data = romf(18'h3FFFF);
    step();
    chk("t4_ok1", req1_ok, 1);
    chk("t4_data1", req1_data, romf(18'h3FFFF));
    rom_ok = 1'b0;
    set_req(0, 1'b0, '0); set_req(1, 1'b0, '0);
    step(); step();

    // Address change with cs held
    set_req(1, 1'b1, 18'h00010);
    serve(18'h00010, romf(18'h00010), 1);
    chk("t5_ok_a", req1_ok, 1);
    set_req(1, 1'b1, 18'h00011);
    step();
    chk("t5_okfall", req1_ok, 0);
    chk("t5_cs", rom_cs, 1);
    chk("t5_addr", rom_addr, 18'h00011);
    serve(18'h00011, romf(18'h00011), 0);
    chk("t5_ok_b", req1_ok, 1);
    chk("t5_data_b", req1_data, romf(18'h00011));
    set_req(1, 1'b0, 18'h00011);
    step(); step();

    // Asynchronous reset during WAIT, then a late rom_ok
    set_req(0, 1'b1, 18'h00777);
    wait_rom_cs(1'b1, "t6_cs");
    step();
    #2 rst = 1'b1;
    #1;
    chk("t6_rom_cs", rom_cs, 0);
    chk("t6_rom_addr", rom_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ok", {req1_ok, req0_ok}, 0);
    chk("t6_data", {req1_data, req0_data}, 0);
    set_req(0, 1'b0, 18'h00777);
    step();
    rst = 1'b0;
    step(); step();
    rom_data = romf(18'h00777);
    rom_ok   = 1'b1;
    step(); step();
    chk("t6_late_ok", {req1_ok, req0_ok}, 0);
    chk("t6_late_busy", busy, 0);
    rom_ok = 1'b0;

    // Randomized traffic
    m_last   = 1'b0;
    m_pp[0]  = req0_addr; m_pp[1] = req1_addr;
    m_wait[0] = 1'b0; m_wait[1] = 1'b0;
    p_rom_cs = rom_cs; p_rom_addr = rom_addr;
    foreach (segs[s]) begin
      en = segs[s];
      for (int c = 0; c < 700; c++) begin
        step();
        model_check();
        rsp_tick();
        drive_reqs(1'b1);
      end
      for (int c = 0; c < 60; c++) begin
        step();
        model_check();
        rsp_tick();
        drive_reqs(1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
